axi_slave_write: RTL and testbench

//  AXI4 write-channel responder (slave side) fronting a 16K x 32 SRAM bank.

---
 rtl/axi_pkg.sv | 32 +++
 rtl/axi_burst_addr_gen.sv | 18 +
 rtl/axi_slave_write.sv | 136 +++++++++++++
 tb/tb_axi_slave_write.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI write-slave types: response codes, burst kinds, FSM states
package axi_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_STRB_W = 4;
  localparam int AXI_LEN_W  = 4;
  localparam int SRAM_AW    = 14;

  localparam logic [2:0] SIZE_4B = 3'd2;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    RESP = 2'd2
  } wr_slv_state_t;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// rtl/axi_burst_addr_gen.sv - next byte address within the 64 KB window for a burst beat
module axi_burst_addr_gen
  import axi_pkg::*;
(
  input  logic [15:0] cur_addr,
  input  burst_t      burst,
  input  logic [2:0]  size,
  output logic [15:0] next_addr
);

  // 16-bit arithmetic makes the word index wrap without touching the window base
  always_comb begin
    next_addr = cur_addr;
    if (burst == BURST_INCR)
      next_addr = cur_addr + (16'd1 << size);
  end

endmodule

// File: rtl/axi_slave_write.sv
// rtl/axi_slave_write.sv - AXI4 write slave into a 16K x 32 SRAM; AXI_SLV_WR_B2B_EN enables AW accept during B
module axi_slave_write
  import axi_pkg::*;
#(
  parameter int          ID_W      = 8,
  parameter logic [31:0] ADDR_BASE = 32'h0001_0000,
  parameter logic [31:0] ADDR_SIZE = 32'h0001_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_W-1:0]       AWID_S,
  input  logic [AXI_ADDR_W-1:0] AWADDR_S,
  input  logic [AXI_LEN_W-1:0]  AWLEN_S,
  input  logic [2:0]            AWSIZE_S,
  input  logic [1:0]            AWBURST_S,
  input  logic                  AWVALID_S,
  output logic                  AWREADY_S,
  input  logic [AXI_DATA_W-1:0] WDATA_S,
  input  logic [AXI_STRB_W-1:0] WSTRB_S,
  input  logic                  WLAST_S,
  input  logic                  WVALID_S,
  output logic                  WREADY_S,
  output logic [ID_W-1:0]       BID_S,
  output logic [1:0]            BRESP_S,
  output logic                  BVALID_S,
  input  logic                  BREADY_S,
  output logic                  sram_cs,
  output logic [3:0]            sram_web,
  output logic [SRAM_AW-1:0]    sram_a,
  output logic [AXI_DATA_W-1:0] sram_di
);

  wr_slv_state_t        state, next_state;
  logic [ID_W-1:0]      id_q;
  logic [15:0]          cur_addr, next_addr;
  logic [AXI_LEN_W-1:0] len_q, beat_cnt;
  burst_t               burst_q;
  logic [2:0]           size_q;
  resp_t                aw_err, resp_q, aw_resp;
  logic                 aw_hs, w_hs, last_beat;

  assign aw_hs     = AWVALID_S & AWREADY_S;
  assign w_hs      = WVALID_S & WREADY_S;
  assign last_beat = (beat_cnt == len_q);
  assign BID_S     = id_q;
  assign BRESP_S   = resp_q;

  // unsigned offset compare covers both ends of the decode window
  always_comb begin
    aw_resp = RESP_OKAY;
    if ((AWADDR_S - ADDR_BASE) >= ADDR_SIZE)
      aw_resp = RESP_DECERR;
    else if (AWSIZE_S != SIZE_4B || burst_t'(AWBURST_S) == BURST_WRAP)
      aw_resp = RESP_SLVERR;
  end

  axi_burst_addr_gen u_addr_gen (
    .cur_addr  (cur_addr),
    .burst     (burst_q),
    .size      (size_q),
    .next_addr (next_addr)
  );

  always_comb begin
    next_state = state;
    AWREADY_S  = 1'b0;
    WREADY_S   = 1'b0;
    BVALID_S   = 1'b0;
    case (state)
      IDLE: begin
        AWREADY_S = 1'b1;
        if (AWVALID_S) next_state = DATA;
      end
      DATA: begin
        WREADY_S = 1'b1;
        if (WVALID_S && last_beat) next_state = RESP;
      end
      RESP: begin
        BVALID_S = 1'b1;
`ifdef AXI_SLV_WR_B2B_EN
        AWREADY_S = BREADY_S;
        if (BREADY_S) next_state = AWVALID_S ? DATA : IDLE;
`else
        if (BREADY_S) next_state = IDLE;
`endif
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      id_q     <= '0;
      cur_addr <= '0;
      len_q    <= '0;
      beat_cnt <= '0;
      burst_q  <= BURST_FIXED;
      size_q   <= '0;
      aw_err   <= RESP_OKAY;
      resp_q   <= RESP_OKAY;
      sram_cs  <= 1'b0;
      sram_web <= 4'hF;
      sram_a   <= '0;
      sram_di  <= '0;
    end else begin
      state    <= next_state;
      sram_cs  <= 1'b0;
      sram_web <= 4'hF;
      if (aw_hs) begin
        id_q     <= AWID_S;
        cur_addr <= AWADDR_S[15:0];
        len_q    <= AWLEN_S;
        burst_q  <= burst_t'(AWBURST_S);
        size_q   <= AWSIZE_S;
        beat_cnt <= '0;
        aw_err   <= aw_resp;
        resp_q   <= aw_resp;
      end
      if (w_hs) begin
        // only errors known at AW time suppress the strobe; a WLAST mismatch just flags the response
        if (aw_err == RESP_OKAY) begin
          sram_cs  <= 1'b1;
          sram_web <= ~WSTRB_S;
          sram_a   <= cur_addr[15:2];
          sram_di  <= WDATA_S;
        end
        cur_addr <= next_addr;
        beat_cnt <= beat_cnt + 4'd1;
        if ((WLAST_S != last_beat) && resp_q == RESP_OKAY)
          resp_q <= RESP_SLVERR;
      end
    end
  end

endmodule

// File: tb/tb_axi_slave_write.sv
// tb/tb_axi_slave_write.sv - table-driven bench for axi_slave_write
module tb_axi_slave_write;
  import axi_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  AWID_S = '0;
  logic [31:0] AWADDR_S = '0;
  logic [3:0]  AWLEN_S = '0;
  logic [2:0]  AWSIZE_S = '0;
  logic [1:0]  AWBURST_S = '0;
  logic        AWVALID_S = 1'b0;
  logic        AWREADY_S;
  logic [31:0] WDATA_S = '0;
  logic [3:0]  WSTRB_S = '0;
  logic        WLAST_S = 1'b0;
  logic        WVALID_S = 1'b0;
  logic        WREADY_S;
  logic [7:0]  BID_S;
  logic [1:0]  BRESP_S;
  logic        BVALID_S;
  logic        BREADY_S = 1'b0;
  logic        sram_cs;
  logic [3:0]  sram_web;
  logic [13:0] sram_a;
  logic [31:0] sram_di;

  always #5 clk = ~clk;

  axi_slave_write dut (
    .clk(clk), .rst(rst),
    .AWID_S(AWID_S), .AWADDR_S(AWADDR_S), .AWLEN_S(AWLEN_S), .AWSIZE_S(AWSIZE_S),
    .AWBURST_S(AWBURST_S), .AWVALID_S(AWVALID_S), .AWREADY_S(AWREADY_S),
    .WDATA_S(WDATA_S), .WSTRB_S(WSTRB_S), .WLAST_S(WLAST_S), .WVALID_S(WVALID_S),
    .WREADY_S(WREADY_S), .BID_S(BID_S), .BRESP_S(BRESP_S), .BVALID_S(BVALID_S),
    .BREADY_S(BREADY_S), .sram_cs(sram_cs), .sram_web(sram_web), .sram_a(sram_a),
    .sram_di(sram_di)
  );

  typedef struct {
    logic [7:0]        id;
    logic [31:0]       addr;
    logic [3:0]        len;
    logic [1:0]        burst;
    logic [2:0]        size;
    int                last_beat;
    logic [3:0][3:0]   strb;
    logic [31:0]       data0;
    int                exp_n;
    logic [3:0][13:0]  exp_a;
    logic [3:0][3:0]   exp_web;
    logic [1:0]        exp_resp;
  } vec_t;

  vec_t vecs[11];
  int tests = 0;
  int fails = 0;

  logic [13:0] cap_a[$];
  logic [3:0]  cap_web[$];
  logic [31:0] cap_di[$];

  always @(negedge clk) begin
    if (rst && sram_cs) begin
      cap_a.push_back(sram_a);
      cap_web.push_back(sram_web);
      cap_di.push_back(sram_di);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_cap();
    cap_a.delete();
    cap_web.delete();
    cap_di.delete();
  endtask

  task automatic do_aw(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                       input logic [1:0] burst, input logic [2:0] size);
    int n = 0;
    AWID_S = id; AWADDR_S = addr; AWLEN_S = len; AWBURST_S = burst; AWSIZE_S = size;
    AWVALID_S = 1'b1;
    @(negedge clk);
    while (!AWREADY_S && n < 50) begin n++; @(negedge clk); end
    tests++;
    if (!AWREADY_S) begin fails++; $display("FAIL aw_timeout: got 0 expected AWREADY 1"); end
    @(posedge clk); #1;
    AWVALID_S = 1'b0;
  endtask

  task automatic do_beat(input logic [31:0] data, input logic [3:0] strb, input logic last);
    int n = 0;
    WVALID_S = 1'b1; WDATA_S = data; WSTRB_S = strb; WLAST_S = last;
    @(negedge clk);
    while (!WREADY_S && n < 50) begin n++; @(negedge clk); end
    tests++;
    if (!WREADY_S) begin fails++; $display("FAIL w_timeout: got 0 expected WREADY 1"); end
    @(posedge clk); #1;
    WVALID_S = 1'b0; WLAST_S = 1'b0;
  endtask

  task automatic get_b(input logic [7:0] id, input logic [1:0] resp);
    int n = 0;
    @(negedge clk);
    chk("b_latency", {31'd0, BVALID_S}, 32'd1);
    while (!BVALID_S && n < 50) begin n++; @(negedge clk); end
    chk("bid", {24'd0, BID_S}, {24'd0, id});
    chk("bresp", {30'd0, BRESP_S}, {30'd0, resp});
    BREADY_S = 1'b1;
    @(posedge clk); #1;
    BREADY_S = 1'b0;
  endtask

  task automatic run_vec(input int k);
    vec_t v;
    v = vecs[k];
    clear_cap();
    do_aw(v.id, v.addr, v.len, v.burst, v.size);
    for (int b = 0; b <= int'(v.len); b++)
      do_beat(v.data0 + b, v.strb[b], b == v.last_beat);
    get_b(v.id, v.exp_resp);
    chk($sformatf("v%0d_nwrites", k), cap_a.size(), v.exp_n);
    for (int i = 0; i < v.exp_n && i < cap_a.size(); i++) begin
      chk($sformatf("v%0d_a%0d", k, i), {18'd0, cap_a[i]}, {18'd0, v.exp_a[i]});
      chk($sformatf("v%0d_web%0d", k, i), {28'd0, cap_web[i]}, {28'd0, v.exp_web[i]});
      chk($sformatf("v%0d_di%0d", k, i), cap_di[i], v.data0 + i);
    end
    chk($sformatf("v%0d_idle", k), {31'd0, AWREADY_S}, 32'd1);
  endtask

  initial begin
    vecs[0]  = '{8'h15, 32'h0001_0040, 4'd0, 2'b01, 3'd2, 0, 16'h000F, 32'hDEAD_BEEF, 1,
                 {14'd0, 14'd0, 14'd0, 14'h010}, 16'h0000, 2'b00};
    vecs[1]  = '{8'h22, 32'h0001_0000, 4'd3, 2'b01, 3'd2, 3, 16'h1C3F, 32'h1111_0000, 4,
                 {14'd3, 14'd2, 14'd1, 14'd0}, 16'hE3C0, 2'b00};
    vecs[2]  = '{8'h33, 32'h0003_0000, 4'd1, 2'b01, 3'd2, 1, 16'h00FF, 32'h2222_0000, 0,
                 {14'd0, 14'd0, 14'd0, 14'd0}, 16'h0000, 2'b11};
    vecs[3]  = '{8'h44, 32'h0001_0100, 4'd2, 2'b01, 3'd2, 1, 16'h0FFF, 32'h3333_0000, 3,
                 {14'd0, 14'h042, 14'h041, 14'h040}, 16'h0000, 2'b10};
    vecs[4]  = '{8'h55, 32'h0001_0008, 4'd2, 2'b00, 3'd2, 2, 16'h0421, 32'h4444_0000, 3,
                 {14'd0, 14'd2, 14'd2, 14'd2}, 16'h0BDE, 2'b00};
    vecs[5]  = '{8'h66, 32'h0001_0000, 4'd1, 2'b10, 3'd2, 1, 16'h00FF, 32'h5555_0000, 0,
                 {14'd0, 14'd0, 14'd0, 14'd0}, 16'h0000, 2'b10};
    vecs[6]  = '{8'h77, 32'h0001_0010, 4'd1, 2'b01, 3'd1, 1, 16'h00FF, 32'h6666_0000, 0,
                 {14'd0, 14'd0, 14'd0, 14'd0}, 16'h0000, 2'b10};
    vecs[7]  = '{8'h88, 32'h0001_FFFC, 4'd1, 2'b01, 3'd2, 1, 16'h00F8, 32'h7777_0000, 2,
                 {14'd0, 14'd0, 14'h0000, 14'h3FFF}, 16'h0007, 2'b00};
    vecs[8]  = '{8'h99, 32'h0001_0020, 4'd1, 2'b01, 3'd2, 9, 16'h00FF, 32'h8888_0000, 2,
                 {14'd0, 14'd0, 14'd9, 14'd8}, 16'h0000, 2'b10};
    vecs[9]  = '{8'hAA, 32'h0000_FFFC, 4'd0, 2'b01, 3'd2, 0, 16'h000F, 32'h9999_0000, 0,
                 {14'd0, 14'd0, 14'd0, 14'd0}, 16'h0000, 2'b11};
    vecs[10] = '{8'hBB, 32'h0002_0000, 4'd0, 2'b01, 3'd2, 0, 16'h000F, 32'hAAAA_0000, 0,
                 {14'd0, 14'd0, 14'd0, 14'd0}, 16'h0000, 2'b11};

    repeat (3) @(negedge clk);
    chk("rst_awready", {31'd0, AWREADY_S}, 32'd1);
    chk("rst_wready", {31'd0, WREADY_S}, 32'd0);
    chk("rst_bvalid", {31'd0, BVALID_S}, 32'd0);
    chk("rst_bid", {24'd0, BID_S}, 32'd0);
    chk("rst_bresp", {30'd0, BRESP_S}, 32'd0);
    chk("rst_cs", {31'd0, sram_cs}, 32'd0);
    chk("rst_web", {28'd0, sram_web}, 32'hF);
    chk("rst_a", {18'd0, sram_a}, 32'd0);
    chk("rst_di", sram_di, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // W traffic with no open burst must not be taken
    clear_cap();
    WVALID_S = 1'b1; WDATA_S = 32'h1234_5678; WSTRB_S = 4'hF; WLAST_S = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_wready", {31'd0, WREADY_S}, 32'd0);
    end
    @(posedge clk); #1;
    WVALID_S = 1'b0; WLAST_S = 1'b0;
    @(negedge clk);
    chk("idle_no_write", cap_a.size(), 32'd0);
    @(posedge clk); #1;

    for (int k = 0; k < 11; k++) run_vec(k);

    // B back-pressure: response held stable, new AW held off
    do_aw(8'h5A, 32'h0001_0200, 4'd0, 2'b01, 3'd2);
    do_beat(32'hCAFE_F00D, 4'hF, 1'b1);
    AWVALID_S = 1'b1; AWADDR_S = 32'h0001_0300; AWID_S = 8'hA5;
    repeat (5) begin
      @(negedge clk);
      chk("bp_bvalid", {31'd0, BVALID_S}, 32'd1);
      chk("bp_bid", {24'd0, BID_S}, 32'h5A);
      chk("bp_bresp", {30'd0, BRESP_S}, 32'd0);
      chk("bp_awready", {31'd0, AWREADY_S}, 32'd0);
    end
    AWVALID_S = 1'b0;
    @(posedge clk); #1;
    BREADY_S = 1'b1;
    @(posedge clk); #1;
    BREADY_S = 1'b0;
    @(negedge clk);
    chk("bp_done_bvalid", {31'd0, BVALID_S}, 32'd0);
    chk("bp_done_awready", {31'd0, AWREADY_S}, 32'd1);
    @(posedge clk); #1;

    // asynchronous reset in the middle of a len=3 burst
    clear_cap();
    do_aw(8'h3C, 32'h0001_0400, 4'd3, 2'b01, 3'd2);
    do_beat(32'h0000_0001, 4'hF, 1'b0);
    do_beat(32'h0000_0002, 4'hF, 1'b0);
    WVALID_S = 1'b1; WDATA_S = 32'h0000_0003; WSTRB_S = 4'hF;
    #2 rst = 1'b0;
    #1;
    chk("ar_cs", {31'd0, sram_cs}, 32'd0);
    chk("ar_web", {28'd0, sram_web}, 32'hF);
    chk("ar_a", {18'd0, sram_a}, 32'd0);
    chk("ar_di", sram_di, 32'd0);
    chk("ar_awready", {31'd0, AWREADY_S}, 32'd1);
    chk("ar_wready", {31'd0, WREADY_S}, 32'd0);
    chk("ar_bid", {24'd0, BID_S}, 32'd0);
    WVALID_S = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("ar_idle_awready", {31'd0, AWREADY_S}, 32'd1);
    chk("ar_idle_wready", {31'd0, WREADY_S}, 32'd0);
    @(posedge clk); #1;
    run_vec(0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
